// File: rtl/lab1_pkg.sv
// Shared definitions for the lab 1 gate checker: state encoding, vector count
// and the legal range of the per-vector settle time.
package lab1_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETTLE = 2'b01,
    ST_CHECK  = 2'b10,
    ST_DONE   = 2'b11
  } lab1StateT;

  localparam int NUM_VEC    = 4;
  localparam int VEC_W      = 2;
  localparam int SETTLE_MIN = 1;
  localparam int SETTLE_MAX = 15;
  localparam int CNT_W      = 4;
  localparam int ERR_W      = 3;

endpackage

// File: rtl/lab1_gate_model.sv
// Golden combinational model of the lab 1 gate unit (AND/OR/NOT-of-A).
module lab1_gate_model (
  output logic expAND,
  output logic expOR,
  output logic expNOT,
  input  logic inA,
  input  logic inB
);

  assign expAND = inA & inB;
  assign expOR  = inA | inB;
  assign expNOT = ~inA;

endmodule

// File: rtl/lab1_gate_checker.sv
// Drives the four (A,B) vectors into the gate unit, waits SETTLE cycles per
// vector, then samples its outputs against the golden model.
//
// state     | meaning
// ST_IDLE   | waiting for start, outputs at reset values
// ST_SETTLE | vector driven, counting settle cycles
// ST_CHECK  | one-cycle compare of gate outputs against model
// ST_DONE   | results held, start restarts a run
module lab1_gate_checker
  import lab1_pkg::*;
#(
  parameter int SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             outA,
  output logic             outB,
  input  logic             inAND,
  input  logic             inOR,
  input  logic             inNOT,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [NUM_VEC-1:0] fail_vec,
  output logic [ERR_W-1:0]   err_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

  lab1StateT          state, stateNext;
  logic [VEC_W-1:0]   vec, vecNext, vecInc;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic [NUM_VEC-1:0] failNext;
  logic [ERR_W-1:0]   errNext;
  logic               aNext, bNext;
  logic               expAND, expOR, expNOT;
  logic               mismatch;

  lab1_gate_model uModel (
    .expAND (expAND),
    .expOR  (expOR),
    .expNOT (expNOT),
    .inA    (outA),
    .inB    (outB)
  );

  // Several bad outputs on one vector still count as a single failure.
  assign mismatch = (inAND != expAND) | (inOR != expOR) | (inNOT != expNOT);
  assign vecInc   = vec + VEC_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      vec       <= '0;
      cnt       <= '0;
      fail_vec  <= '0;
      err_count <= '0;
      outA      <= 1'b0;
      outB      <= 1'b0;
    end else begin
      state     <= stateNext;
      vec       <= vecNext;
      cnt       <= cntNext;
      fail_vec  <= failNext;
      err_count <= errNext;
      outA      <= aNext;
      outB      <= bNext;
    end
  end

  always_comb begin
    stateNext = state;
    vecNext   = vec;
    cntNext   = cnt;
    failNext  = fail_vec;
    errNext   = err_count;
    aNext     = outA;
    bNext     = outB;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          stateNext = ST_SETTLE;
          vecNext   = '0;
          cntNext   = '0;
          failNext  = '0;
          errNext   = '0;
          aNext     = 1'b0;
          bNext     = 1'b0;
        end
      end
      ST_SETTLE: begin
        cntNext = cnt + CNT_W'(1);
        if (cnt == LAST_CNT) begin
          stateNext = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (mismatch) begin
          failNext[vec] = 1'b1;
          errNext       = err_count + ERR_W'(1);
        end
        if (vec == LAST_VEC) begin
          stateNext = ST_DONE;
        end else begin
          stateNext = ST_SETTLE;
          vecNext   = vecInc;
          aNext     = vecInc[1];
          bNext     = vecInc[0];
          cntNext   = '0;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  assign busy = (state == ST_SETTLE) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = (state == ST_DONE) && (fail_vec == '0);

endmodule

// File: tb/tb_lab1_gate_checker.sv
// Scoreboard bench for lab1_gate_checker: a behavioural gate unit with
// selectable faults feeds the checker, expected results are queued per run.
module tb_lab1_gate_checker;

  typedef struct {
    logic [3:0] failVec;
    logic [2:0] errCount;
    logic       passExp;
  } resT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start1 = 1'b0;
  logic outA, outB, inAND, inOR, inNOT, busy, done, pass;
  logic [3:0] failVec;
  logic [2:0] errCount;
  logic outA1, outB1, busy1, done1, pass1;
  logic [3:0] failVec1;
  logic [2:0] errCount1;
  int mode = 0;

  int total = 0;
  int bad = 0;
  resT resQ[$];
  logic [1:0] vecQ[$];

  always #5 clk = ~clk;

  // Gate unit under various faults: 0 good, 1 AND tied 0, 2 NOT=A, 3 AND/OR stuck 1.
  always_comb begin
    inAND = outA & outB;
    inOR  = outA | outB;
    inNOT = ~outA;
    case (mode)
      1: inAND = 1'b0;
      2: inNOT = outA;
      3: begin inAND = 1'b1; inOR = 1'b1; end
      default: ;
    endcase
  end

  lab1_gate_checker #(.SETTLE(2)) dut (
    .clk(clk), .reset(reset), .start(start),
    .outA(outA), .outB(outB),
    .inAND(inAND), .inOR(inOR), .inNOT(inNOT),
    .busy(busy), .done(done), .pass(pass),
    .fail_vec(failVec), .err_count(errCount)
  );

  lab1_gate_checker #(.SETTLE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1),
    .outA(outA1), .outB(outB1),
    .inAND(outA1 & outB1), .inOR(outA1 | outB1), .inNOT(~outA1),
    .busy(busy1), .done(done1), .pass(pass1),
    .fail_vec(failVec1), .err_count(errCount1)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic waitEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic runCheck(input int m, input logic [3:0] ef, input logic [2:0] ec,
                          input logic ep, input bit hold);
    int e;
    bit seen;
    resT r;
    mode = m;
    resQ.push_back('{failVec: ef, errCount: ec, passExp: ep});
    vecQ.delete();
    for (int i = 0; i < 12; i++) vecQ.push_back(2'(i / 3));
    start = 1'b1;
    waitEdge();
    if (!hold) start = 1'b0;
    checkVal("startBusy", 32'(busy), 32'd1);
    checkVal("startDone", 32'(done), 32'd0);
    checkVal("startFail", 32'(failVec), 32'd0);
    checkVal("startErr", 32'(errCount), 32'd0);
    e = 0;
    seen = 1'b0;
    while (!seen && e < 40) begin
      if (done) seen = 1'b1;
      else begin
        if (vecQ.size() > 0) checkVal("vecStep", 32'({outA, outB}), 32'(vecQ.pop_front()));
        waitEdge();
        e++;
      end
    end
    start = 1'b0;
    if (!seen) begin
      checkVal("doneTimeout", 32'(e), 32'd12);
      resQ.delete();
    end else begin
      r = resQ.pop_front();
      checkVal("doneCycle", 32'(e), 32'd12);
      checkVal("failVec", 32'(failVec), 32'(r.failVec));
      checkVal("errCount", 32'(errCount), 32'(r.errCount));
      checkVal("pass", 32'(pass), 32'(r.passExp));
      checkVal("lastVec", 32'({outA, outB}), 32'd3);
      checkVal("busyDone", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int e;
    #2;
    checkVal("rstOut", 32'({outA, outB, busy, done, pass}), 32'd0);
    checkVal("rstFail", 32'(failVec), 32'd0);
    checkVal("rstErr", 32'(errCount), 32'd0);
    waitEdge();
    reset = 1'b0;
    waitEdge();
    checkVal("idleDone", 32'(done), 32'd0);

    runCheck(0, 4'b0000, 3'd0, 1'b1, 1'b0);
    runCheck(1, 4'b1000, 3'd1, 1'b0, 1'b0);
    runCheck(2, 4'b1111, 3'd4, 1'b0, 1'b0);
    runCheck(3, 4'b0111, 3'd3, 1'b0, 1'b0);
    runCheck(0, 4'b0000, 3'd0, 1'b1, 1'b1);

    // Reset mid-run during cycle 5 (vector 1 driven), checked before the next edge.
    mode = 0;
    start = 1'b1;
    waitEdge();
    start = 1'b0;
    for (int i = 0; i < 4; i++) waitEdge();
    checkVal("preRstB", 32'({outA, outB}), 32'd1);
    reset = 1'b1;
    #1;
    checkVal("asyncRstOut", 32'({outA, outB, busy, done, pass}), 32'd0);
    checkVal("asyncRstErr", 32'({failVec, errCount}), 32'd0);
    waitEdge();
    reset = 1'b0;
    waitEdge();
    runCheck(0, 4'b0000, 3'd0, 1'b1, 1'b0);

    start1 = 1'b1;
    waitEdge();
    start1 = 1'b0;
    e = 0;
    while (!done1 && e < 40) begin
      waitEdge();
      e++;
    end
    checkVal("s1DoneCycle", 32'(e), 32'd8);
    checkVal("s1Pass", 32'(pass1), 32'd1);
    checkVal("s1Err", 32'({failVec1, errCount1}), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
